// File: rtl/pf_ccc_phase_ctrl.sv
// pf_ccc_phase_ctrl: DDR4 CCC PLL power-down and dynamic phase-shift sequencer.
// Define PHASE_CTRL_LOCK_MON_EN to add the LOSS_CNT lock-loss counter output.
module pf_ccc_phase_ctrl #(
    parameter int PD_HOLD      = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int STEP_GAP     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       PD_REQ,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_SEL,
    input  logic       REQ_DIR,
    input  logic [7:0] REQ_STEPS,
    output logic       BUSY,
    output logic       DONE,
    output logic       LOCKED,
    output logic       LOCK_ERR,
    output logic [2:0] POS0,
    output logic [2:0] POS2,
    output logic [2:0] POS3,
    output logic       PLL_POWERDOWN_N,
    output logic       PHASE_OUT0_SEL,
    output logic       PHASE_OUT2_SEL,
    output logic       PHASE_OUT3_SEL,
    output logic       PHASE_DIRECTION,
    output logic       PHASE_ROTATE,
    output logic       LOAD_PHASE_N
`ifdef PHASE_CTRL_LOCK_MON_EN
    ,
    output logic [7:0] LOSS_CNT
`endif
);

    localparam int CMAX = (LOCK_TIMEOUT > PD_HOLD)
        ? ((LOCK_TIMEOUT > STEP_GAP) ? LOCK_TIMEOUT : STEP_GAP)
        : ((PD_HOLD > STEP_GAP) ? PD_HOLD : STEP_GAP);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PD_LAST  = CW'(PD_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STEP_GAP - 2);

    typedef enum logic [2:0] {
        S_PWRDN,
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_LOAD,
        S_FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_m;
    logic          lock_s;
    logic [1:0]    sel_q;
    logic          dir_q;
    logic [7:0]    rem;

    logic       in_step;
    logic       abort;
    logic       idle_loss;
    logic       lost;
    logic       step_now;
    logic [2:0] delta;
    logic [2:0] hits;

    // {OUT0, OUT2, OUT3} enables for a select code; code 3 drives all three
    function automatic logic [2:0] sel_hits(input logic [1:0] s);
        return {s == 2'd0 || s == 2'd3,
                s == 2'd1 || s == 2'd3,
                s == 2'd2 || s == 2'd3};
    endfunction

    always_comb begin
        in_step   = (state == S_SETUP) || (state == S_PULSE) ||
                    (state == S_GAP) || (state == S_LOAD);
        abort     = in_step && !lock_s;
        idle_loss = (state == S_IDLE) && !lock_s;
        lost      = abort || idle_loss;
        step_now  = lock_s && ((state == S_SETUP) ||
                    ((state == S_GAP) && (cnt == GAP_LAST) && (rem != 8'd0)));
        delta     = dir_q ? 3'd1 : 3'd7;
        hits      = sel_hits(sel_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= PLL_LOCK;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= S_PWRDN;
            cnt             <= '0;
            sel_q           <= 2'd0;
            dir_q           <= 1'b0;
            rem             <= 8'd0;
            REQ_READY       <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            LOCKED          <= 1'b0;
            LOCK_ERR        <= 1'b0;
            PLL_POWERDOWN_N <= 1'b0;
            PHASE_OUT0_SEL  <= 1'b0;
            PHASE_OUT2_SEL  <= 1'b0;
            PHASE_OUT3_SEL  <= 1'b0;
            PHASE_DIRECTION <= 1'b0;
            PHASE_ROTATE    <= 1'b0;
            LOAD_PHASE_N    <= 1'b1;
        end else if (lost) begin
            state           <= S_PWRDN;
            cnt             <= '0;
            REQ_READY       <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            LOCKED          <= 1'b0;
            PLL_POWERDOWN_N <= 1'b0;
            PHASE_OUT0_SEL  <= 1'b0;
            PHASE_OUT2_SEL  <= 1'b0;
            PHASE_OUT3_SEL  <= 1'b0;
            PHASE_DIRECTION <= 1'b0;
            PHASE_ROTATE    <= 1'b0;
            LOAD_PHASE_N    <= 1'b1;
        end else begin
            unique case (state)
                S_PWRDN: begin
                    if (cnt == PD_LAST) begin
                        state           <= S_WAIT_LOCK;
                        cnt             <= '0;
                        PLL_POWERDOWN_N <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state     <= S_IDLE;
                        LOCKED    <= 1'b1;
                        REQ_READY <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state           <= S_PWRDN;
                        cnt             <= '0;
                        LOCK_ERR        <= 1'b1;
                        PLL_POWERDOWN_N <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        REQ_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        sel_q     <= REQ_SEL;
                        dir_q     <= REQ_DIR;
                        rem       <= REQ_STEPS;
                        if (REQ_STEPS == 8'd0) begin
                            state <= S_FIN;
                            DONE  <= 1'b1;
                        end else begin
                            state           <= S_SETUP;
                            {PHASE_OUT0_SEL, PHASE_OUT2_SEL,
                             PHASE_OUT3_SEL} <= sel_hits(REQ_SEL);
                            PHASE_DIRECTION <= REQ_DIR;
                        end
                    end else if (PD_REQ) begin
                        state           <= S_PWRDN;
                        cnt             <= '0;
                        REQ_READY       <= 1'b0;
                        LOCKED          <= 1'b0;
                        PLL_POWERDOWN_N <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state        <= S_PULSE;
                    PHASE_ROTATE <= 1'b1;
                    rem          <= rem - 8'd1;
                end
                S_PULSE: begin
                    state        <= S_GAP;
                    cnt          <= '0;
                    PHASE_ROTATE <= 1'b0;
                end
                S_GAP: begin
                    if (cnt != GAP_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (rem != 8'd0) begin
                        state        <= S_PULSE;
                        PHASE_ROTATE <= 1'b1;
                        rem          <= rem - 8'd1;
                    end else begin
                        state        <= S_LOAD;
                        LOAD_PHASE_N <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state           <= S_FIN;
                    LOAD_PHASE_N    <= 1'b1;
                    DONE            <= 1'b1;
                    PHASE_OUT0_SEL  <= 1'b0;
                    PHASE_OUT2_SEL  <= 1'b0;
                    PHASE_OUT3_SEL  <= 1'b0;
                    PHASE_DIRECTION <= 1'b0;
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    DONE      <= 1'b0;
                    BUSY      <= 1'b0;
                    REQ_READY <= 1'b1;
                end
            endcase
        end
    end

    // Position moves together with the PHASE_ROTATE pulse it accounts for
    always_ff @(posedge CLK) begin
        if (RESET || state == S_PWRDN) begin
            POS0 <= 3'd0;
            POS2 <= 3'd0;
            POS3 <= 3'd0;
        end else if (step_now) begin
            if (hits[2]) POS0 <= POS0 + delta;
            if (hits[1]) POS2 <= POS2 + delta;
            if (hits[0]) POS3 <= POS3 + delta;
        end
    end

`ifdef PHASE_CTRL_LOCK_MON_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LOSS_CNT <= 8'd0;
        end else if (lost && LOCKED && LOSS_CNT != 8'hFF) begin
            LOSS_CNT <= LOSS_CNT + 8'd1;
        end
    end
`endif

endmodule
